controlador_estados_param: RTL
==============================

Name: controlador_estados_param

Overview:
Parametrised next-generation pet state controller. It samples the two push-buttons over a programmable decision window and moves between IDLE, COMENDO, DORMINDO, DANDO_AULA and MORTO. It adds a per-action timeout, active death detection on the three need levels, and an explicit revive path. It sits between the button debouncers and the need counters and display logic, and drives the same 4-bit state code used downstream.

Parameters:
STAT_W, 8, width of fome/felicidade/sono.
JANELA_W, 16, decision-window counter width; window length = 2^JANELA_W cycles.
TEMPO_ACAO, 8, number of windows an action state lasts without button input before returning to IDLE; legal range 1..255.
LIMIAR_MORTE, 0, death threshold; a need <= LIMIAR_MORTE is fatal.

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous, active-high reset
b1  in  1  button 1, synchronous level, already debounced
b2  in  1  button 2, synchronous level, already debounced
reviver  in  1  revive request, honoured only in MORTO
fome  in  STAT_W  hunger level
felicidade  in  STAT_W  happiness level
sono  in  STAT_W  sleep level
estado  out  4  IDLE=0000, DORMINDO=0001, COMENDO=0010, DANDO_AULA=0100, MORTO=1000
tick  out  1  one-cycle pulse in the decision cycle
restante  out  8  windows left in the current action; 0 outside action states

Behaviour:
- Reset (async, any time, including mid-window or mid-action):
  - estado=IDLE, window counter=0, button latches=0, restante=0, tick=0.
- Window counter:
  - Free-running, increments every cycle and wraps at 2^JANELA_W.
  - Decision cycle = cycle where counter == 2^JANELA_W-1. tick is combinationally high in that cycle only.
  - First decision is the 2^JANELA_W-th rising edge after reset release.
- Button latches:
  - b1_l is set by b1=1 in any cycle of the window; b2_l likewise from b2.
  - Effective press in the decision cycle: B1 = b1_l | b1, B2 = b2_l | b2.
  - Both latches clear on the decision edge.
  - A press of 1 cycle anywhere in the window counts. Presses in different cycles of the same window count as simultaneous.
- Death check:
  - dead = (fome<=LIMIAR_MORTE) | (felicidade<=LIMIAR_MORTE) | (sono<=LIMIAR_MORTE), unsigned compare.
  - Evaluated only in decision cycles.
- Transitions (decision edge only; otherwise estado and restante hold). Priority top-down:
  1. estado != MORTO and dead -> MORTO, restante=0.
  2. MORTO:
     - reviver=1 and !dead -> IDLE.
     - Otherwise stay MORTO. Buttons are ignored.
     - reviver is sampled in the decision cycle only.
  3. IDLE:
     - B1&!B2 -> COMENDO.
     - !B1&B2 -> DORMINDO.
     - B1&B2 -> DANDO_AULA.
     - none -> IDLE.
     - On entering an action, restante=TEMPO_ACAO.
  4. Action state (COMENDO, DORMINDO or DANDO_AULA):
     - B1|B2 -> IDLE, restante=0. An action-to-action switch requires passing through IDLE.
     - Else if restante==1 -> IDLE, restante=0.
     - Else restante decrements by 1.
- restante is TEMPO_ACAO zero-extended to 8 bits; it never underflows.
- estado must never take a value outside the five codes.

Test Plan:
- JANELA_W=2, TEMPO_ACAO=3, LIMIAR_MORTE=0, all needs=8'd100: reset, b1 pulsed 1 cycle at cycle 1 -> tick at cycle 3, estado=0010 after that edge, restante=3.
- Same setup, no further presses -> restante 3→2→1 on successive ticks, then estado=0000 and restante=0 on the 3rd tick after entry.
- Same setup, b1 at cycle 1 and b2 at cycle 2 of one window -> estado=0100 (DANDO_AULA). In the next window, b2 pressed -> estado=0000, not DORMINDO.
- In DORMINDO, sono forced to 0 mid-window -> estado unchanged until the next tick, then 1000 and restante=0. Buttons in later windows keep 1000. reviver=1 at a tick while sono=0 -> stays 1000. sono=50 with reviver=1 at the next tick -> 0000.
- Assert rst mid-action, on a non-tick cycle with a latched b1 -> estado=0000 and restante=0 immediately (asynchronously). The latch is cleared, so no transition occurs at the first post-reset tick.
- JANELA_W=16, defaults: hold b2 continuously from reset -> first transition (to 0001) exactly at the 65536th edge. tick is high only on cycles 65535, 131071, ...

Source files
------------

// File: rtl/controlador_estados_param_if.sv
// Pet controller bus: buttons, revive, need levels in; state code, tick, remaining windows out.
// slave = controller side, master = environment side.
interface controlador_estados_param_if #(
  parameter int STAT_W = 8
);
  logic              b1;
  logic              b2;
  logic              reviver;
  logic [STAT_W-1:0] fome;
  logic [STAT_W-1:0] felicidade;
  logic [STAT_W-1:0] sono;
  logic [3:0]        estado;
  logic              tick;
  logic [7:0]        restante;

  modport slave (
    input  b1,
    input  b2,
    input  reviver,
    input  fome,
    input  felicidade,
    input  sono,
    output estado,
    output tick,
    output restante
  );

  modport master (
    output b1,
    output b2,
    output reviver,
    output fome,
    output felicidade,
    output sono,
    input  estado,
    input  tick,
    input  restante
  );
endinterface

// File: rtl/controlador_estados_param.sv
// Pet state controller: windowed button decisions, action timeout, death and revive.
// Ports: clk, rst (async high), bus (slave: b1/b2/reviver/needs in; estado/tick/restante out).
module controlador_estados_param #(
  parameter int STAT_W       = 8,
  parameter int JANELA_W     = 16,
  parameter int TEMPO_ACAO   = 8,
  parameter int LIMIAR_MORTE = 0
) (
  input  logic                        clk,
  input  logic                        rst,
  controlador_estados_param_if.slave  bus
);

  typedef enum logic [3:0] {
    IDLE       = 4'b0000,
    DORMINDO   = 4'b0001,
    COMENDO    = 4'b0010,
    DANDO_AULA = 4'b0100,
    MORTO      = 4'b1000
  } estado_t;

  localparam logic [STAT_W-1:0] LIM   = STAT_W'(LIMIAR_MORTE);
  localparam logic [7:0]        TEMPO = 8'(TEMPO_ACAO);

  estado_t             st_q;
  estado_t             st_d;
  logic [JANELA_W-1:0] cnt_q;
  logic                b1_l;
  logic                b2_l;
  logic [7:0]          rest_q;
  logic [7:0]          rest_d;
  logic                tick;
  logic                p1;
  logic                p2;
  logic                dead;

  assign tick = &cnt_q;
  // a press in the decision cycle itself still counts
  assign p1   = b1_l | bus.b1;
  assign p2   = b2_l | bus.b2;
  assign dead = (bus.fome <= LIM)
              | (bus.felicidade <= LIM)
              | (bus.sono <= LIM);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q   <= IDLE;
      cnt_q  <= '0;
      b1_l   <= 1'b0;
      b2_l   <= 1'b0;
      rest_q <= 8'd0;
    end else begin
      cnt_q  <= cnt_q + 1'b1;
      st_q   <= st_d;
      rest_q <= rest_d;
      if (tick) begin
        b1_l <= 1'b0;
        b2_l <= 1'b0;
      end else begin
        b1_l <= b1_l | bus.b1;
        b2_l <= b2_l | bus.b2;
      end
    end
  end

  always_comb begin
    st_d   = st_q;
    rest_d = rest_q;
    if (tick) begin
      if (st_q != MORTO && dead) begin
        st_d   = MORTO;
        rest_d = 8'd0;
      end else begin
        unique case (st_q)
          MORTO: begin
            if (bus.reviver && !dead) begin
              st_d   = IDLE;
              rest_d = 8'd0;
            end
          end
          IDLE: begin
            unique case (1'b1)
              (p1 && p2): begin
                st_d   = DANDO_AULA;
                rest_d = TEMPO;
              end
              (p1 && !p2): begin
                st_d   = COMENDO;
                rest_d = TEMPO;
              end
              (!p1 && p2): begin
                st_d   = DORMINDO;
                rest_d = TEMPO;
              end
              default: begin
                st_d   = IDLE;
                rest_d = 8'd0;
              end
            endcase
          end
          DORMINDO, COMENDO, DANDO_AULA: begin
            // leaving an action always goes through IDLE
            if (p1 || p2 || rest_q <= 8'd1) begin
              st_d   = IDLE;
              rest_d = 8'd0;
            end else begin
              rest_d = rest_q - 8'd1;
            end
          end
          default: begin
            st_d   = IDLE;
            rest_d = 8'd0;
          end
        endcase
      end
    end
  end

  assign bus.estado   = st_q;
  assign bus.tick     = tick;
  assign bus.restante = rest_q;

endmodule
